// File: rtl/reg_file_rd.sv
// 32 x 32-bit register file with two combinational read ports, write-first bypass,
// and a self-sequencing clear that zeroes registers 1..31 after reset or on request.
module reg_file_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              clr_req,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              busy,
  output logic              write_drop
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_W-1:0] IDX_FIRST = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic              w_wr_req;
  logic              w_wr_en;
  logic [DATA_W-1:0] r_regs [0:(1<<ADDR_W)-1];

  assign w_wr_req = RegWrite && (WriteReg != '0);
  // A write only lands in IDLE when no clear is being requested on the same edge.
  assign w_wr_en  = (r_state == IDLE) && w_wr_req && !clr_req;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_drop_nxt  = w_wr_req && ((r_state == CLEAR) || clr_req);
    case (r_state)
      CLEAR: begin
        if (r_idx == IDX_LAST) w_state_nxt = IDLE;
        else                   w_idx_nxt   = r_idx + IDX_FIRST;
      end
      IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = IDX_FIRST;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= IDX_FIRST;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Storage is not reset; the clear walk is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR)
      r_regs[r_idx] <= '0;
    else if (w_wr_en)
      r_regs[WriteReg] <= WriteData;
  end

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (r_state == IDLE) begin
      if (rs != '0) ReadData1 = (w_wr_en && (WriteReg == rs)) ? WriteData : r_regs[rs];
      if (rt != '0) ReadData2 = (w_wr_en && (WriteReg == rt)) ? WriteData : r_regs[rt];
    end
  end

  assign busy       = (r_state == CLEAR);
  assign write_drop = r_drop;

endmodule
